// File: rtl/fas_pkg.sv
// Shared types and helpers for the FAS FFT drain path.
package fas_pkg;

  localparam int unsigned FAS_NBIN = 16;
  localparam int unsigned FAS_DW   = 16;
  localparam int unsigned FAS_IDXW = 4;
  localparam int unsigned FAS_MAGW = 2 * FAS_DW + 1;

  // One FFT bin: real in the upper half, imaginary in the lower half
  typedef struct packed {
    logic signed [FAS_DW-1:0] re;
    logic signed [FAS_DW-1:0] im;
  } fas_cplx_t;

  typedef logic [FAS_MAGW-1:0] fas_mag_t;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } fas_rd_state_t;

  // Squared magnitude; each square is non-negative so zero-extension is exact
  function automatic fas_mag_t fas_mag(input fas_cplx_t c);
    logic signed [2*FAS_DW-1:0] w_re2;
    logic signed [2*FAS_DW-1:0] w_im2;
    w_re2 = c.re * c.re;
    w_im2 = c.im * c.im;
    return FAS_MAGW'($unsigned(w_re2)) + FAS_MAGW'($unsigned(w_im2));
  endfunction

endpackage

// File: rtl/fas_frame_bank.sv
// Two-bank frame buffer: pointers, full flags and bank availability.
module fas_frame_bank
  import fas_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wr_en,
  input  fas_cplx_t [FAS_NBIN-1:0]     i_wr_data,
  input  logic                         i_rd_free,
  input  logic      [FAS_IDXW-1:0]     i_rd_idx,
  output fas_cplx_t                    o_rd_data,
  output logic                         o_wr_accept,
  output logic                         o_rd_full_nxt
);

  logic [1:0]                 r_full;
  logic                       r_wr_ptr;
  logic                       r_rd_ptr;
  fas_cplx_t [FAS_NBIN-1:0]   r_mem [2];

  logic       w_wr;
  logic       w_rd_ptr_nxt;
  logic [1:0] w_full_nxt;

  // A bank freed by the final beat can be refilled on the same edge
  always_comb begin
    w_wr         = i_wr_en & (~(&r_full) | i_rd_free);
    w_rd_ptr_nxt = r_rd_ptr ^ i_rd_free;
    w_full_nxt   = r_full;
    if (i_rd_free) w_full_nxt[r_rd_ptr] = 1'b0;
    if (w_wr)      w_full_nxt[r_wr_ptr] = 1'b1;
  end

  assign o_wr_accept   = w_wr;
  assign o_rd_full_nxt = w_full_nxt[w_rd_ptr_nxt];
  assign o_rd_data     = r_mem[r_rd_ptr][i_rd_idx];

  // Bank bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full   <= 2'b00;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      r_full   <= w_full_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      if (w_wr) r_wr_ptr <= ~r_wr_ptr;
    end
  end

  // Frame storage, written whole in one cycle
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/fas_fft_drain.sv
// Drains 16-bin FFT bursts as indexed beats and reports each frame's peak bin.
module fas_fft_drain
  import fas_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [3:0]  out_idx,
  output logic        out_last,
  output logic        peak_valid,
  output logic [3:0]  peak_idx,
  output logic        overflow,
  output logic [7:0]  frame_cnt
);

  localparam logic [FAS_IDXW-1:0] LAST_IDX = FAS_IDXW'(FAS_NBIN - 1);

  fas_rd_state_t            r_state;
  fas_rd_state_t            w_state_nxt;
  logic [FAS_IDXW-1:0]      r_idx;
  fas_mag_t                 r_max;
  logic [FAS_IDXW-1:0]      r_max_idx;
  logic [FAS_IDXW-1:0]      r_peak_idx;
  logic                     r_peak_valid;
  logic                     r_overflow;
  logic [7:0]               r_frame_cnt;

  fas_cplx_t [FAS_NBIN-1:0] w_frame;
  fas_cplx_t                w_rd_data;
  fas_mag_t                 w_mag;
  logic                     w_hs;
  logic                     w_last_hs;
  logic                     w_wr_accept;
  logic                     w_rd_full_nxt;

  assign w_frame[0]  = fas_cplx_t'(fft_d0);
  assign w_frame[1]  = fas_cplx_t'(fft_d1);
  assign w_frame[2]  = fas_cplx_t'(fft_d2);
  assign w_frame[3]  = fas_cplx_t'(fft_d3);
  assign w_frame[4]  = fas_cplx_t'(fft_d4);
  assign w_frame[5]  = fas_cplx_t'(fft_d5);
  assign w_frame[6]  = fas_cplx_t'(fft_d6);
  assign w_frame[7]  = fas_cplx_t'(fft_d7);
  assign w_frame[8]  = fas_cplx_t'(fft_d8);
  assign w_frame[9]  = fas_cplx_t'(fft_d9);
  assign w_frame[10] = fas_cplx_t'(fft_d10);
  assign w_frame[11] = fas_cplx_t'(fft_d11);
  assign w_frame[12] = fas_cplx_t'(fft_d12);
  assign w_frame[13] = fas_cplx_t'(fft_d13);
  assign w_frame[14] = fas_cplx_t'(fft_d14);
  assign w_frame[15] = fas_cplx_t'(fft_d15);

  assign w_hs      = out_valid & out_ready;
  assign w_last_hs = w_hs & (r_idx == LAST_IDX);
  assign w_mag     = fas_mag(w_rd_data);

  fas_frame_bank u_bank (
    .clk           (clk),
    .rst           (rst),
    .i_wr_en       (fft_valid),
    .i_wr_data     (w_frame),
    .i_rd_free     (w_last_hs),
    .i_rd_idx      (r_idx),
    .o_rd_data     (w_rd_data),
    .o_wr_accept   (w_wr_accept),
    .o_rd_full_nxt (w_rd_full_nxt)
  );

  // Read FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RD_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state looks at the bank fill after this edge so a fresh capture streams immediately
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RD_IDLE:   if (w_rd_full_nxt) w_state_nxt = RD_STREAM;
      RD_STREAM: if (w_last_hs && !w_rd_full_nxt) w_state_nxt = RD_IDLE;
      default:   w_state_nxt = RD_IDLE;
    endcase
  end

  // Stream outputs decoded from state and beat counter
  always_comb begin
    out_valid = (r_state == RD_STREAM);
    out_last  = (r_state == RD_STREAM) && (r_idx == LAST_IDX);
    out_idx   = r_idx;
    out_data  = w_rd_data;
  end

  // Beat counter, peak tracker, frame counter and drop flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx        <= '0;
      r_max        <= '0;
      r_max_idx    <= '0;
      r_peak_idx   <= '0;
      r_peak_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_peak_valid <= w_last_hs;
      r_overflow   <= fft_valid & ~w_wr_accept;
      if (w_hs) begin
        r_idx <= w_last_hs ? '0 : r_idx + FAS_IDXW'(1);
        if ((r_idx == '0) || (w_mag > r_max)) begin
          r_max     <= w_mag;
          r_max_idx <= r_idx;
        end
      end
      if (w_last_hs) begin
        r_peak_idx  <= (w_mag > r_max) ? r_idx : r_max_idx;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign peak_valid = r_peak_valid;
  assign peak_idx   = r_peak_idx;
  assign overflow   = r_overflow;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_fas_fft_drain.sv
// Directed bench for fas_fft_drain with a beat scoreboard and peak model.
module tb_fas_fft_drain;

  typedef logic [31:0] frame_t [16];
  typedef struct {
    logic [31:0] data;
    logic [3:0]  idx;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        fft_valid;
  logic [31:0] d [16];
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic        out_last;
  logic        peak_valid;
  logic [3:0]  peak_idx;
  logic        overflow;
  logic [7:0]  frame_cnt;

  int total = 0;
  int bad   = 0;

  beat_t      sb [$];
  logic [3:0] pq [$];
  logic [3:0] exp_peak;
  logic [7:0] exp_frames = 8'd0;
  logic       pend_peak  = 1'b0;
  logic       ovf_due    = 1'b0;
  int         hs_cnt     = 0;

  fas_fft_drain dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]),   .fft_d1(d[1]),   .fft_d2(d[2]),   .fft_d3(d[3]),
    .fft_d4(d[4]),   .fft_d5(d[5]),   .fft_d6(d[6]),   .fft_d7(d[7]),
    .fft_d8(d[8]),   .fft_d9(d[9]),   .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .peak_valid(peak_valid),
    .peak_idx(peak_idx), .overflow(overflow), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference peak: first bin with the largest re^2+im^2
  function automatic logic [3:0] model_peak(input frame_t f);
    longint best = -1;
    longint re, im, m;
    logic [3:0] bi = 4'd0;
    for (int i = 0; i < 16; i++) begin
      re = longint'($signed(f[i][31:16]));
      im = longint'($signed(f[i][15:0]));
      m  = re * re + im * im;
      if (m > best) begin
        best = m;
        bi   = 4'(i);
      end
    end
    return bi;
  endfunction

  // Present one burst for one edge; expected beats queued if it should be kept
  task automatic send_burst(input frame_t f, input bit drop);
    beat_t b;
    for (int i = 0; i < 16; i++) d[i] = f[i];
    fft_valid = 1'b1;
    @(posedge clk);
    if (drop) ovf_due = 1'b1;
    else begin
      for (int i = 0; i < 16; i++) begin
        b.data = f[i];
        b.idx  = 4'(i);
        sb.push_back(b);
      end
      pq.push_back(model_peak(f));
    end
    #1 fft_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    bit done = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !pend_peak) begin
        done = 1;
        break;
      end
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < 16; i++) f[i] = $urandom;
    return f;
  endfunction

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    beat_t h;
    if (!rst) begin
      chk("overflow", 64'(overflow), 64'(ovf_due));
      ovf_due = 1'b0;
      if (pend_peak) begin
        chk("peak_valid", 64'(peak_valid), 64'd1);
        chk("peak_idx", 64'(peak_idx), 64'(exp_peak));
        chk("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
        pend_peak = 1'b0;
      end else begin
        chk("peak_quiet", 64'(peak_valid), 64'd0);
      end
      chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      if (out_valid && sb.size() != 0) begin
        h = sb[0];
        chk("out_data", 64'(out_data), 64'(h.data));
        chk("out_idx", 64'(out_idx), 64'(h.idx));
        chk("out_last", 64'(out_last), 64'(h.idx == 4'd15));
        if (out_ready) begin
          void'(sb.pop_front());
          hs_cnt++;
          if (h.idx == 4'd15) begin
            exp_peak   = pq.pop_front();
            exp_frames = exp_frames + 8'd1;
            pend_peak  = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f;
    frame_t fa;
    frame_t fb;
    int hs0;
    bit found;

    rst       = 1'b1;
    fft_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) d[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_idx", 64'(out_idx), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_pv", 64'(peak_valid), 64'd0);
    chk("rst_pidx", 64'(peak_idx), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_fcnt", 64'(frame_cnt), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Ramp frame, ready held high: peak at the top bin
    for (int i = 0; i < 16; i++) f[i] = {16'(i), 16'h0000};
    send_burst(f, 0);
    wait_drain("t1_drain");
    chk("t1_fcnt", 64'(frame_cnt), 64'd1);
    chk("t1_peak", 64'(peak_idx), 64'd15);

    // Equal magnitudes of different sign/axis: lowest index wins
    for (int i = 0; i < 16; i++) f[i] = 32'd0;
    f[3] = {16'hFF00, 16'h0000};
    f[9] = {16'hFF00, 16'h0000};
    f[7] = {16'h0000, 16'h0100};
    send_burst(f, 0);
    wait_drain("t2_drain");
    chk("t2_peak", 64'(peak_idx), 64'd3);

    // Back-pressure with ready toggling every cycle
    out_ready = 1'b0;
    send_burst(rand_frame(), 0);
    hs0 = hs_cnt;
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      out_ready = ~out_ready;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    chk("t3_beats", 64'(hs_cnt - hs0), 64'd16);
    wait_drain("t3_drain");

    // Three back-to-back bursts into a stalled drain: third is dropped
    out_ready = 1'b0;
    fa = rand_frame();
    fb = rand_frame();
    send_burst(fa, 0);
    send_burst(fb, 0);
    send_burst(rand_frame(), 1);
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain("t4_drain");
    chk("t4_fcnt", 64'(frame_cnt), 64'(exp_frames));

    // New burst lands on the same edge that frees a full bank
    out_ready = 1'b0;
    send_burst(rand_frame(), 0);
    send_burst(rand_frame(), 0);
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (out_valid && out_idx == 4'd15 && sb.size() == 16) begin
        found = 1;
        break;
      end
    end
    chk("t5_sync", 64'(found), 64'd1);
    send_burst(rand_frame(), 0);
    wait_drain("t5_drain");

    // Asynchronous reset in the middle of a frame
    send_burst(rand_frame(), 0);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (out_valid && out_idx == 4'd6) begin
        found = 1;
        break;
      end
    end
    chk("t6_reach", 64'(found), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_idx", 64'(out_idx), 64'd0);
    chk("t6_last", 64'(out_last), 64'd0);
    chk("t6_pv", 64'(peak_valid), 64'd0);
    chk("t6_fcnt", 64'(frame_cnt), 64'd0);
    sb.delete();
    pq.delete();
    exp_frames = 8'd0;
    pend_peak  = 1'b0;
    ovf_due    = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_burst(rand_frame(), 0);
    wait_drain("t6_drain");
    chk("t6_fcnt_after", 64'(frame_cnt), 64'd1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fas_fft_drain.md
Name: fas_fft_drain

Overview:
- Consumer for the FFT result port of the FAS block.
- Captures each 16-bin parallel burst (one cycle of fft_valid with fft_d0..fft_d15) into a two-bank frame buffer.
- Streams the bins out one per beat on a valid/ready interface, tagged with the bin index.
- Reports the bin with the largest magnitude for every frame. Bursts that arrive while both banks are full are dropped and flagged.

Parameters:
- NBIN, 16, bins per frame (fixed by the FAS interface; index width is log2(NBIN) = 4).
- DW, 16, width of each real and imaginary field.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fft_valid  in  1  one-cycle strobe: all sixteen fft_dN inputs hold a frame.
- fft_d0 .. fft_d15  in  32 each  bin N: real in [31:16], imag in [15:0], two's complement.
- out_ready  in  1  downstream accepts a beat.
- out_valid  out  1  beat available.
- out_data  out  32  current bin word, unchanged from capture.
- out_idx  out  4  bin index of the current beat, 0..15.
- out_last  out  1  high on the beat with out_idx = 15.
- peak_valid  out  1  one-cycle pulse after a frame's last beat completes its handshake.
- peak_idx  out  4  index of the max-magnitude bin of that frame; held until the next pulse.
- overflow  out  1  one-cycle pulse when an fft_valid burst is dropped.
- frame_cnt  out  8  count of frames fully drained; wraps 255 -> 0.

Behaviour:
- Reset values (async, rst high): out_valid = 0, out_idx = 0, out_last = 0, peak_valid = 0, peak_idx = 0, overflow = 0, frame_cnt = 0. Both banks empty; write and read pointers = 0; beat counter = 0; running max = 0.
- out_data is undefined while out_valid = 0. The bench must not check it then.
- Reset mid-frame discards all buffered data. No peak_valid is produced for a partial frame.
- Capture: on a rising edge with fft_valid = 1 and a bank available, all 16 words are written to the bank at the write pointer. The bank is marked full and the write pointer toggles.
- A bank is available when fewer than 2 banks are full, or when exactly 2 are full and the last beat (out_last && out_ready) completes in the same cycle. The simultaneous case is accepted with no drop.
- Drop: fft_valid = 1 with no bank available. The burst is ignored and overflow pulses in the next cycle. Buffered data is untouched.
- Latency: a burst captured at edge N into empty banks gives out_valid = 1 after edge N, with out_idx = 0.
- Read FSM has two states:
  - IDLE: out_valid = 0. Go to STREAM when the bank at the read pointer is full.
  - STREAM: out_valid = 1. On each out_ready handshake, out_idx increments. At idx 15, the bank is freed, the read pointer toggles and the index returns to 0. Stay in STREAM if the other bank is full, with no bubble; otherwise go to IDLE.
- While out_ready = 0, out_data, out_idx and out_last hold stable.
- Magnitude for each beat = re*re + im*im, computed with signed 16x16 multiplies into a 33-bit unsigned sum. It is evaluated only on handshake beats.
- Running max: loaded unconditionally on idx 0; updated only when the new magnitude is strictly greater, so ties keep the lowest index.
- After the idx-15 handshake, the edge updates peak_idx (including bin 15 in the comparison), pulses peak_valid for one cycle and increments frame_cnt.
- fft_valid held high for consecutive cycles is treated as one burst per cycle, each subject to the availability rule.

Decomposition:
- Shared package fas_pkg holds:
  - constants FAS_NBIN = 16, FAS_DW = 16, FAS_IDXW = 4;
  - typedef fas_cplx_t (packed struct: signed re, signed im);
  - typedef fas_mag_t (33-bit unsigned);
  - function fas_mag(fas_cplx_t).
- One sub-module, fas_frame_bank: 2x16x32 storage with write/read pointers, full flags and the availability logic.
- The top holds the read FSM, the peak tracker and the counters.

Test Plan:
- Single frame, out_ready tied to 1, bin N = {N, 0} in 16-bit fields -> out_valid from the cycle after capture; 16 consecutive beats with idx 0..15 and matching data; out_last on beat 15; peak_idx = 15; peak_valid one cycle later; frame_cnt = 1.
- Tie and sign case: bins 3 and 9 = {16'hFF00, 0} (-256), bin 7 = {0, 16'h0100} (+256), all others 0 -> peak_idx = 3.
- Back-pressure: out_ready toggled 1,0,1,0 -> each beat held stable while out_ready = 0; all 16 beats appear in order; beat count = 16.
- Overflow: out_ready = 0, three bursts on consecutive cycles -> first two captured, overflow pulses once after the third; draining yields frames 1 then 2; frame_cnt = 2.
- Simultaneous free: both banks full, fft_valid asserted in the same cycle as the idx-15 handshake -> no overflow; the third frame drains next with no bubble.
- Async reset asserted at idx 6 of a frame -> all outputs at reset values immediately; no peak_valid; a new frame after release drains from idx 0.
